// File: rtl/i2c_write_sequencer.sv
// Purpose: single-byte I2C master write (START, addr+W, ACK, data, ACK, STOP) paced by an external baud generator.
// Latency: all outputs registered; bus pins move one clock after each detected ClockI2C edge, Done one clock after the final fall.
// Backpressure: none; Start is accepted only in IDLE and ignored while a frame is in flight (no queuing).
module i2c_write_sequencer (
    input  logic       clock,
    input  logic       Reset,
    input  logic       Start,
    input  logic [6:0] SlaveAddress,
    input  logic [7:0] WriteData,
    input  logic       ClockI2C,
    input  logic       SDA_in,
    output logic       BaudEnable,
    output logic       SCL,
    output logic       SDA_out,
    output logic       Busy,
    output logic       Done,
    output logic       AckError
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ACK1,
        S_DATA,
        S_ACK2,
        S_STOP,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        prev_q, prev_d;
    logic        scl_q, scl_d;
    logic        sda_q, sda_d;
    logic        baud_q, baud_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ack_err_q, ack_err_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  data_q, data_d;
    logic [2:0]  cnt_q, cnt_d;
    // Set once bit 0 of the current byte is on the wire; the next fall releases SDA for ACK.
    logic        last_q, last_d;

    logic        rise;
    logic        fall;

    assign rise = ClockI2C & ~prev_q;
    assign fall = ~ClockI2C & prev_q;

    // Next-state and registered-output computation for the frame sequencer.
    always_comb begin
        state_d   = state_q;
        prev_d    = ClockI2C;
        scl_d     = scl_q;
        sda_d     = sda_q;
        baud_d    = baud_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ack_err_d = ack_err_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        last_d    = last_q;

        case (state_q)
            S_IDLE: begin
                scl_d  = 1'b1;
                sda_d  = 1'b1;
                baud_d = 1'b0;
                busy_d = 1'b0;
                // A coincident ClockI2C edge is irrelevant here; Start wins.
                if (Start) begin
                    shreg_d   = {SlaveAddress, 1'b0};
                    data_d    = WriteData;
                    ack_err_d = 1'b0;
                    baud_d    = 1'b1;
                    busy_d    = 1'b1;
                    sda_d     = 1'b0;
                    state_d   = S_START;
                end
            end

            S_START: begin
                // SDA low with SCL high is the start condition; wait for the generator's first rise.
                scl_d = 1'b1;
                sda_d = 1'b0;
                if (rise) begin
                    cnt_d   = 3'd7;
                    last_d  = 1'b0;
                    state_d = S_ADDR;
                end
            end

            S_ADDR, S_DATA: begin
                scl_d = ClockI2C;
                if (fall) begin
                    if (last_q) begin
                        sda_d   = 1'b1;
                        state_d = (state_q == S_ADDR) ? S_ACK1 : S_ACK2;
                    end else begin
                        sda_d   = shreg_q[7];
                        shreg_d = {shreg_q[6:0], 1'b0};
                        if (cnt_q == 3'd0) begin
                            last_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q - 3'd1;
                        end
                    end
                end
            end

            S_ACK1, S_ACK2: begin
                scl_d = ClockI2C;
                if (rise && SDA_in) begin
                    ack_err_d = 1'b1;
                end
                if (fall) begin
                    if ((state_q == S_ACK1) && !ack_err_q) begin
                        // Data bit 7 goes out on the same fall that closes the address ACK.
                        sda_d   = data_q[7];
                        shreg_d = {data_q[6:0], 1'b0};
                        cnt_d   = 3'd6;
                        last_d  = 1'b0;
                        state_d = S_DATA;
                    end else begin
                        sda_d   = 1'b0;
                        state_d = S_STOP;
                    end
                end
            end

            S_STOP: begin
                // SCL parks high on the rise; SDA rising on the following fall is the stop condition.
                if (rise) begin
                    scl_d = 1'b1;
                end
                if (fall) begin
                    sda_d   = 1'b1;
                    baud_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset; reset abandons any frame without a stop condition.
    always_ff @(posedge clock) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            prev_q    <= 1'b0;
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
            baud_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            shreg_q   <= 8'h00;
            data_q    <= 8'h00;
            cnt_q     <= 3'd0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            scl_q     <= scl_d;
            sda_q     <= sda_d;
            baud_q    <= baud_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
        end
    end

    assign BaudEnable = baud_q;
    assign SCL        = scl_q;
    assign SDA_out    = sda_q;
    assign Busy       = busy_q;
    assign Done       = done_q;
    assign AckError   = ack_err_q;

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Purpose: bench for i2c_write_sequencer with a baud-generator/slave model and a bus-level frame reference.
// Latency: frames are checked bit-for-bit as seen by a slave sampling SDA on SCL rising, plus Done timing.
// Backpressure: none; every wait on the DUT is bounded and an expired bound is counted as a failure.
module tb_i2c_write_sequencer;

    logic       clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic [6:0] SlaveAddress = 7'h00;
    logic [7:0] WriteData = 8'h00;
    logic       ClockI2C = 1'b0;
    logic       SDA_in = 1'b1;
    logic       BaudEnable;
    logic       SCL;
    logic       SDA_out;
    logic       Busy;
    logic       Done;
    logic       AckError;

    i2c_write_sequencer dut (
        .clock        (clock),
        .Reset        (Reset),
        .Start        (Start),
        .SlaveAddress (SlaveAddress),
        .WriteData    (WriteData),
        .ClockI2C     (ClockI2C),
        .SDA_in       (SDA_in),
        .BaudEnable   (BaudEnable),
        .SCL          (SCL),
        .SDA_out      (SDA_out),
        .Busy         (Busy),
        .Done         (Done),
        .AckError     (AckError)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Baud generator / slave model state.
    int cyc = 0;
    int divc = 0;
    int nfalls = 0;
    int last_fall_cyc = 0;
    bit ack1_v = 1'b0;
    bit ack2_v = 1'b0;

    // Bus monitor state.
    bit cap_q[$];
    int done_cnt = 0;
    int done_cyc = 0;
    int done_nfalls = 0;
    logic done_err = 1'b0;
    int n_starts = 0;
    int n_stops = 0;
    logic scl_s = 1'b1;
    logic sda_s = 1'b1;

    typedef struct {
        logic [6:0] addr;
        logic [7:0] data;
        bit         ack1;
        bit         ack2;
        bit         exp_err;
        int         exp_len;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bits a slave would latch on each SCL rise: address byte, ACK slot, data byte, ACK slot, stop-setup low.
    function automatic logic [31:0] model_bits(input logic [6:0] a, input logic [7:0] d, input bit a1);
        logic [31:0] v;
        logic [7:0]  ab;
        ab = {a, 1'b0};
        v  = 32'd0;
        for (int i = 7; i >= 0; i--) v = {v[30:0], ab[i]};
        v = {v[30:0], 1'b1};
        if (!a1) begin
            for (int i = 7; i >= 0; i--) v = {v[30:0], d[i]};
            v = {v[30:0], 1'b1};
        end
        v = {v[30:0], 1'b0};
        return v;
    endfunction

    // Baud generator toggles every 5 clocks while enabled; slave drives ACK during the ninth and eighteenth fall windows.
    always @(negedge clock) begin
        if (!BaudEnable) begin
            ClockI2C = 1'b0;
            divc     = 0;
            nfalls   = 0;
        end else if (divc == 4) begin
            divc     = 0;
            ClockI2C = ~ClockI2C;
            if (!ClockI2C) begin
                nfalls++;
                last_fall_cyc = cyc;
            end
        end else begin
            divc++;
        end
        SDA_in = (nfalls == 9) ? ack1_v : (nfalls == 18) ? ack2_v : 1'b1;
    end

    // Monitor samples just after each rising clock edge: slave bit capture, start/stop conditions, Done pulses.
    always @(posedge clock) begin
        cyc = cyc + 1;
        #1;
        if (SCL && !scl_s) cap_q.push_back(SDA_out);
        if (scl_s && SCL && sda_s && !SDA_out) n_starts++;
        if (scl_s && SCL && !sda_s && SDA_out) n_stops++;
        if (Done) begin
            done_cnt++;
            done_cyc    = cyc;
            done_nfalls = nfalls;
            done_err    = AckError;
        end
        scl_s = SCL;
        sda_s = SDA_out;
    end

    task automatic send(input logic [6:0] a, input logic [7:0] d, input bit a1, input bit a2,
                        input bit exp_err, input int exp_len, input bit inject, input bit linger,
                        input string tag);
        logic [31:0] exp_v;
        logic [31:0] got_v;
        int          budget;
        bit          injected;
        exp_v  = model_bits(a, d, a1);
        ack1_v = a1;
        ack2_v = a2;
        cap_q.delete();
        done_cnt = 0;
        n_starts = 0;
        n_stops  = 0;
        SlaveAddress = a;
        WriteData    = d;
        Start        = 1'b1;
        @(posedge clock); #2;
        Start = 1'b0;
        chk({tag, " start"}, 32'({BaudEnable, Busy, SCL, SDA_out, AckError}), 32'b11100);
        budget   = 0;
        injected = 1'b0;
        while (done_cnt == 0 && budget < 3000) begin
            if (inject && !injected && nfalls == 12) begin
                WriteData = 8'hFF;
                Start     = 1'b1;
                injected  = 1'b1;
            end else begin
                WriteData = d;
                Start     = 1'b0;
            end
            @(posedge clock); #2;
            budget++;
        end
        Start     = 1'b0;
        WriteData = d;
        chk({tag, " done seen"}, 32'(done_cnt), 32'd1);
        got_v = 32'd0;
        foreach (cap_q[i]) got_v = {got_v[30:0], cap_q[i]};
        chk({tag, " nbits"}, 32'(cap_q.size()), 32'(exp_len));
        chk({tag, " bits"}, got_v, exp_v);
        chk({tag, " ackerr"}, 32'(done_err), 32'(exp_err));
        chk({tag, " done lag"}, 32'(done_cyc - last_fall_cyc), 32'd1);
        chk({tag, " falls"}, 32'(done_nfalls), a1 ? 32'd11 : 32'd20);
        chk({tag, " start/stop"}, 32'(n_starts * 16 + n_stops), 32'd17);
        if (linger) begin
            repeat (4) begin
                @(posedge clock); #2;
            end
            chk({tag, " one done"}, 32'(done_cnt), 32'd1);
            chk({tag, " idle"}, 32'({Busy, BaudEnable, SCL, SDA_out}), 32'b0011);
            chk({tag, " ackerr held"}, 32'(AckError), 32'(exp_err));
        end
    endtask

    initial begin
        int  budget;
        bit  reached;
        logic [6:0] ra;
        logic [7:0] rd;
        bit  r1;
        bit  r2;

        vecs[0] = '{addr: 7'h2A, data: 8'hC3, ack1: 1'b0, ack2: 1'b0, exp_err: 1'b0, exp_len: 19};
        vecs[1] = '{addr: 7'h2A, data: 8'hC3, ack1: 1'b1, ack2: 1'b0, exp_err: 1'b1, exp_len: 10};
        vecs[2] = '{addr: 7'h2A, data: 8'hC3, ack1: 1'b0, ack2: 1'b1, exp_err: 1'b1, exp_len: 19};
        vecs[3] = '{addr: 7'h7F, data: 8'h00, ack1: 1'b0, ack2: 1'b0, exp_err: 1'b0, exp_len: 19};
        vecs[4] = '{addr: 7'h00, data: 8'hFF, ack1: 1'b0, ack2: 1'b0, exp_err: 1'b0, exp_len: 19};

        // Reset state.
        @(posedge clock); #2;
        chk("reset outs", 32'({SCL, SDA_out, BaudEnable, Busy, Done, AckError}), 32'b110000);
        @(posedge clock); #2;
        Reset = 1'b0;
        @(posedge clock); #2;
        chk("post reset idle", 32'({SCL, SDA_out, BaudEnable, Busy, Done, AckError}), 32'b110000);

        // Spec vector for 2A/C3: the bus reads 0101_0100, ack, 1100_0011, ack, stop-low.
        chk("model 2A/C3", model_bits(7'h2A, 8'hC3, 1'b0), 32'b0101_0100_1_1100_0011_1_0);

        for (int i = 0; i < 5; i++) begin
            send(vecs[i].addr, vecs[i].data, vecs[i].ack1, vecs[i].ack2,
                 vecs[i].exp_err, vecs[i].exp_len, 1'b0, 1'b1, $sformatf("vec%0d", i));
        end

        // Start with WriteData=FF mid-DATA must not disturb the byte on the bus.
        send(7'h2A, 8'hC3, 1'b0, 1'b0, 1'b0, 19, 1'b1, 1'b1, "busy start");

        // Back-to-back: NACK frame, then Start in the cycle after Done clears AckError.
        send(7'h15, 8'h5A, 1'b1, 1'b0, 1'b1, 10, 1'b0, 1'b0, "b2b first");
        @(posedge clock); #2;
        send(7'h6B, 8'h96, 1'b0, 1'b0, 1'b0, 19, 1'b0, 1'b1, "b2b second");

        // Reset mid-address: 2 cycles of Reset return everything to reset values.
        ack1_v = 1'b0;
        SlaveAddress = 7'h2A;
        WriteData    = 8'hC3;
        Start        = 1'b1;
        @(posedge clock); #2;
        Start   = 1'b0;
        budget  = 0;
        while (nfalls < 4 && budget < 500) begin
            @(posedge clock); #2;
            budget++;
        end
        reached = (nfalls >= 4);
        chk("rst mid-addr reached", 32'({reached, Busy}), 32'b11);
        Reset = 1'b1;
        @(posedge clock); #2;
        chk("rst mid-addr outs", 32'({SCL, SDA_out, BaudEnable, Busy, Done, AckError}), 32'b110000);
        @(posedge clock); #2;
        Reset = 1'b0;
        @(posedge clock); #2;
        chk("rst mid-addr idle", 32'({SCL, SDA_out, BaudEnable, Busy, Done}), 32'b11000);
        send(7'h33, 8'hA5, 1'b0, 1'b0, 1'b0, 19, 1'b0, 1'b1, "after rst");

        // Random frames against the bus-level reference.
        for (int k = 0; k < 8; k++) begin
            ra = 7'($urandom_range(0, 127));
            rd = 8'($urandom_range(0, 255));
            r1 = ($urandom_range(0, 3) == 0);
            r2 = ($urandom_range(0, 2) == 0);
            send(ra, rd, r1, r2, r1 | r2, r1 ? 10 : 19, 1'b0, 1'b1, $sformatf("rand%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
